// File: rtl/seq_frame_arbiter.sv
// seq_frame_arbiter: round-robin sharing of one serial stimulus line among
// several frame requesters, with per-frame counting of detector hits.
module seq_frame_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int DRAIN_CYC = 2,
  parameter int CNT_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic                       s_in,
  input  logic                       valid,
  output logic                       done,
  output logic [$clog2(NUM_REQ)-1:0] done_id,
  output logic [CNT_W-1:0]           hit_cnt
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [3:0]          drain_q, drain_d;
  logic [CNT_W-1:0]    hits_q, hits_d;
  logic [IW-1:0]       win_q, win_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                busy_q, busy_d;
  logic                s_in_q, s_in_d;
  logic                done_q, done_d;
  logic [IW-1:0]       done_id_q, done_id_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;

  // Arbitration result: first requester at or above the pointer, wrapping
  logic                found;
  logic [IW-1:0]       pick;
  logic [IW-1:0]       pick_next;
  logic [DATA_W-1:0]   pick_data;
  logic [CNT_W-1:0]    hits_inc;

  // Round-robin search over requesters starting at the pointer
  always_comb begin
    logic [IW:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(off);
      if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
      if (!found && req[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
    pick_next = (pick == IW'(NUM_REQ-1)) ? '0 : pick + 1'b1;
    pick_data = req_data[int'(pick)*DATA_W +: DATA_W];
    // Saturating increment so a long frame cannot wrap the hit count
    hits_inc  = (valid && (hits_q != '1)) ? hits_q + 1'b1 : hits_q;
  end

  // Next-state and next-output computation for the frame FSM
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    drain_d   = drain_q;
    hits_d    = hits_q;
    win_d     = win_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    s_in_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    hit_cnt_d = hit_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = SHIFT;
          // MSB goes straight to s_in; the register keeps the remaining bits
          s_in_d  = pick_data[DATA_W-1];
          shift_d = {pick_data[DATA_W-2:0], 1'b0};
          gnt_d   = NUM_REQ'(1) << pick;
          win_d   = pick;
          ptr_d   = pick_next;
          bit_d   = '0;
          hits_d  = '0;
        end
      end
      SHIFT: begin
        hits_d = hits_inc;
        if (bit_q == BW'(DATA_W-1)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          bit_d   = bit_q + 1'b1;
          s_in_d  = shift_q[DATA_W-1];
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
        end
      end
      DRAIN: begin
        hits_d = hits_inc;
        if (drain_q == 4'(DRAIN_CYC-1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          done_id_d = win_q;
          hit_cnt_d = hits_inc;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        // req is deliberately ignored here to force one IDLE cycle
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any frame silently
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_q     <= '0;
      drain_q   <= '0;
      hits_q    <= '0;
      win_q     <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      s_in_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      drain_q   <= drain_d;
      hits_q    <= hits_d;
      win_q     <= win_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      s_in_q    <= s_in_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign s_in    = s_in_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_seq_frame_arbiter.sv
// Bench for seq_frame_arbiter: directed scenarios plus random traffic,
// checked by a frame-level reference model and a decoupled monitor.
module tb_seq_frame_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 2;
  localparam int C = 4;
  localparam int FRAME = W + D + 2;  // grant-to-grant spacing under load

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           valid;
  logic [N-1:0]   gnt;
  logic           busy, s_in, done;
  logic [1:0]     done_id;
  logic [C-1:0]   hit_cnt;

  seq_frame_arbiter #(.NUM_REQ(N), .DATA_W(W), .DRAIN_CYC(D), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .busy(busy), .s_in(s_in), .valid(valid), .done(done), .done_id(done_id),
    .hit_cnt(hit_cnt)
  );

  // Wide-frame DUT for hit-count saturation
  logic        rst2_n;
  logic [1:0]  req2;
  logic [63:0] req_data2;
  logic        valid2;
  logic [1:0]  gnt2;
  logic        busy2, s_in2, done2;
  logic [0:0]  done_id2;
  logic [3:0]  hit_cnt2;

  seq_frame_arbiter #(.NUM_REQ(2), .DATA_W(32), .DRAIN_CYC(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst2_n), .req(req2), .req_data(req_data2), .gnt(gnt2),
    .busy(busy2), .s_in(s_in2), .valid(valid2), .done(done2), .done_id(done_id2),
    .hit_cnt(hit_cnt2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state (frame-level: edge numbers, not FSM states)
  typedef struct { int id; int hits; } done_t;
  int       gq[$];
  done_t    dq[$];
  int       edge_n = 0;
  bit       active = 0;
  int       gedge = 0;
  int       next_ok = 0;
  int       ptr = 0;
  int       wid = 0;
  int       hits = 0;
  logic [W-1:0] fdata = '0;
  bit       mon_en = 0;
  logic [N-1:0] exp_gnt = '0;
  bit       exp_busy = 0, exp_sin = 0, exp_done = 0;
  int       held_id = 0, held_hits = 0;
  bit       sat_done = 0;

  // Model: at each edge decide grants, hit attribution and frame completion
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (!rst_n) begin
        mon_en = 1;
        active = 0; ptr = 0; hits = 0;
        gq.delete(); dq.delete();
        held_id = 0; held_hits = 0;
        next_ok = edge_n + 1;
        exp_gnt = '0; exp_done = 0; exp_busy = 0; exp_sin = 0;
      end else begin
        int k;
        exp_gnt = '0;
        exp_done = 0;
        if (active) begin
          k = edge_n - gedge;
          // valid sampled at edges 1..W+D after the grant edge belongs to the frame
          if (k >= 1 && k <= W + D && valid && hits < (1 << C) - 1) hits++;
          if (k == W + D) begin
            done_t r;
            r.id = wid; r.hits = hits;
            dq.push_back(r);
            held_id = wid; held_hits = hits;
            exp_done = 1;
            active = 0;
          end
        end
        if (!active && edge_n >= next_ok && req != 0) begin
          for (int off = 0; off < N; off++) begin
            int idx;
            idx = (ptr + off) % N;
            if (!active && req[idx]) begin
              active = 1;
              wid = idx;
            end
          end
          gedge = edge_n;
          hits = 0;
          fdata = req_data[wid*W +: W];
          ptr = (wid + 1) % N;
          exp_gnt = N'(1) << wid;
          gq.push_back(wid);
          next_ok = edge_n + W + D + 2;
        end
        if (active) begin
          k = edge_n - gedge;
          exp_busy = 1;
          exp_sin = (k < W) ? fdata[W-1-k] : 1'b0;
        end else begin
          exp_busy = exp_done;
          exp_sin = 0;
        end
      end
    end
  end

  // Monitor: compares DUT outputs mid-cycle; pops scoreboard on gnt/done
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("busy", busy, exp_busy);
        check("s_in", s_in, exp_sin);
        check("gnt_vec", gnt, exp_gnt);
        check("done", done, exp_done);
        check("done_id_held", done_id, held_id);
        check("hit_cnt_held", hit_cnt, held_hits);
        if (gnt !== '0) begin
          if (gq.size() == 0) check("gnt_unexpected", gnt, 0);
          else begin
            int w;
            w = gq.pop_front();
            check("gnt_sb", gnt, N'(1) << w);
          end
        end
        if (done === 1'b1) begin
          if (dq.size() == 0) check("done_unexpected", done, 0);
          else begin
            done_t r;
            r = dq.pop_front();
            check("done_id_sb", done_id, r.id);
            check("hit_cnt_sb", hit_cnt, r.hits);
          end
        end
      end
    end
  end

  // Saturation: valid held high across a 32-bit frame with a 4-bit counter
  initial begin
    bit got;
    int lat;
    got = 0; lat = 0;
    rst2_n = 0; req2 = '0; req_data2 = '0; valid2 = 0;
    repeat (2) @(negedge clk);
    rst2_n = 1;
    req_data2[31:0] = 32'hA5A5_0F0F;
    req2 = 2'b01;
    valid2 = 1;
    @(negedge clk);
    req2 = '0;
    check("sat_gnt", gnt2, 2'b01);
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (done2 === 1'b1) begin
        got = 1;
        lat = t + 1;
      end
    end
    if (!got) check("sat_done_timeout", 0, 1);
    else begin
      check("sat_latency", lat, 34);
      check("sat_hit_cnt", hit_cnt2, 15);
      check("sat_done_id", done_id2, 0);
      sat_done = 1;
    end
    valid2 = 0;
  end

  // Stimulus driver
  initial begin
    rst_n = 0; req = '0; req_data = '0; valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);

    // Single frame from requester 1
    req_data[1*W +: W] = 8'hB4;
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    repeat (14) @(negedge clk);

    // Hit counting: valid in IDLE is ignored, two pulses inside the frame
    valid = 1;
    repeat (3) @(negedge clk);
    req_data[0 +: W] = 8'hFF;
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    for (int k = 0; k < W + D + 3; k++) begin
      valid = (k == 3) || (k == W + 1);
      @(negedge clk);
    end
    valid = 0;

    // Round robin under full load, then a sparse request pattern
    req = 4'b1111;
    repeat (8 * FRAME) @(negedge clk);
    req = 4'b1001;
    repeat (2 * FRAME) @(negedge clk);
    req = '0;
    repeat (14) @(negedge clk);

    // Data changed right after the grant must not disturb the frame
    req_data[2*W +: W] = 8'h0F;
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    req_data[2*W +: W] = 8'hF0;
    repeat (14) @(negedge clk);

    // Reset during SHIFT bit 4, then requester 0 must win first
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    req = 4'b0011;
    @(negedge clk);
    req = '0;
    repeat (14) @(negedge clk);

    // Random traffic with occasional resets
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
      valid = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      @(negedge clk);
    end
    rst_n = 1; req = '0; valid = 0;
    repeat (20) @(negedge clk);

    check("gnt_queue_empty", gq.size(), 0);
    check("done_queue_empty", dq.size(), 0);
    check("sat_finished", sat_done, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
